alu_issuer: RTL

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_issuer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_issuer.sv
// Single-outstanding request front end for a shared multi-cycle ALU: latches a request,
// issues it for exactly one cycle, collects the result (or flags an error) and holds it until taken.
module alu_issuer #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_operandA,
  output logic [31:0]      alu_operandB,
  output logic [2:0]       alu_operation,
  output logic             alu_operation_valid,
  input  logic [63:0]      alu_result,
  input  logic             alu_busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_error,
  output logic [15:0]      issue_count
);

  localparam int         CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [2:0] {IDLE, ISSUE, CAP_AS, WAIT_HI, WAIT_LO, RESP} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [63:0]        rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_error_q, rsp_error_d;
  logic [15:0]        issue_count_q, issue_count_d;
  logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d, busy_cnt_inc;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= OP_NOP;
      a_q           <= '0;
      b_q           <= '0;
      rsp_result_q  <= '0;
      rsp_tag_q     <= '0;
      rsp_error_q   <= 1'b0;
      issue_count_q <= '0;
      busy_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_result_q  <= rsp_result_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_error_q   <= rsp_error_d;
      issue_count_q <= issue_count_d;
      busy_cnt_q    <= busy_cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_result_d  = rsp_result_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_error_d   = rsp_error_q;
    issue_count_d = issue_count_q;
    busy_cnt_d    = busy_cnt_q;
    busy_cnt_inc  = busy_cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (req_valid && !alu_busy) begin
          op_d      = req_op;
          a_d       = req_a;
          b_d       = req_b;
          rsp_tag_d = req_tag;
          if (req_op[2]) begin
            rsp_result_d = '0;
            rsp_error_d  = 1'b1;
            state_d      = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        issue_count_d = issue_count_q + 16'd1;
        busy_cnt_d    = '0;
        // op[1] separates the multi-cycle mul/div from single-cycle add/sub.
        state_d       = op_q[1] ? WAIT_HI : CAP_AS;
      end
      CAP_AS: begin
        rsp_result_d = alu_result;
        rsp_error_d  = 1'b0;
        state_d      = RESP;
      end
      WAIT_HI: begin
        if (alu_busy) begin
          state_d = WAIT_LO;
        end else begin
          rsp_result_d = '0;
          rsp_error_d  = 1'b1;
          state_d      = RESP;
        end
      end
      WAIT_LO: begin
        if (alu_busy) begin
          busy_cnt_d = busy_cnt_inc;
          if (busy_cnt_inc == CNT_W'(TIMEOUT)) begin
            rsp_result_d = '0;
            rsp_error_d  = 1'b1;
            state_d      = RESP;
          end
        end else begin
          rsp_result_d = alu_result;
          rsp_error_d  = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The ALU only ever sees a real opcode during the single ISSUE cycle.
  always_comb begin
    req_ready           = (state_q == IDLE) && !alu_busy;
    alu_operation       = OP_NOP;
    alu_operation_valid = 1'b0;
    alu_operandA        = '0;
    alu_operandB        = '0;
    if (state_q == ISSUE) begin
      alu_operation       = op_q;
      alu_operation_valid = 1'b1;
      alu_operandA        = a_q;
      alu_operandB        = b_q;
    end
    rsp_valid   = (state_q == RESP);
    rsp_result  = rsp_result_q;
    rsp_tag     = rsp_tag_q;
    rsp_error   = rsp_error_q;
    issue_count = issue_count_q;
  end

endmodule
